// File: rtl/alu_modport.sv
// 8-bit ALU: result/flags registered one CE cycle after sampling, half-valid operands wait up to 16 CE cycles.
// No backpressure; outputs float while RST is low and until the first executed operation.
module alu_modport #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  CE,
    input  logic [DATA_WIDTH-1:0] OPA,
    input  logic [DATA_WIDTH-1:0] OPB,
    input  logic                  CIN,
    input  logic                  MODE,
    input  logic [1:0]            INP_VALID,
    input  logic [CMD_WIDTH-1:0]  CMD,
    output logic [DATA_WIDTH:0]   RES,
    output logic                  COUT,
    output logic                  OFLOW,
    output logic                  G,
    output logic                  L,
    output logic                  E,
    output logic                  ERR
);
    localparam int SH_W = $clog2(DATA_WIDTH);

    typedef struct packed {
        logic [DATA_WIDTH:0] res;
        logic                cout;
        logic                oflow;
        logic                g;
        logic                l;
        logic                e;
        logic                err;
    } out_t;

    out_t                  out_q, out_d;
    logic                  drv_q, drv_d;
    logic                  wait_q, wait_d;
    logic                  hold_a_q, hold_a_d;
    logic                  mode_q, mode_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;

    function automatic out_t err_out();
        out_t o;
        o     = '0;
        o.err = 1'b1;
        return o;
    endfunction

    function automatic logic bad_cmd(input logic md, input logic [CMD_WIDTH-1:0] cmd);
        int c;
        c = int'(cmd);
        return md ? (c > 8) : (c > 13);
    endfunction

    function automatic logic need_a_only(input logic md, input logic [CMD_WIDTH-1:0] cmd);
        int c;
        c = int'(cmd);
        return md ? (c == 4 || c == 5) : (c == 6 || c == 8 || c == 9);
    endfunction

    function automatic logic need_b_only(input logic md, input logic [CMD_WIDTH-1:0] cmd);
        int c;
        c = int'(cmd);
        return md ? (c == 6 || c == 7) : (c == 7 || c == 10 || c == 11);
    endfunction

    function automatic out_t exec(input logic md, input logic [CMD_WIDTH-1:0] cmd,
                                  input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                                  input logic cin);
        out_t                    o;
        logic [DATA_WIDTH:0]     ax, bx, ci, one, t;
        logic [2*DATA_WIDTH-1:0] aa, rl, rr;
        logic [SH_W-1:0]         amt;
        o   = '0;
        ax  = {1'b0, a};
        bx  = {1'b0, b};
        ci  = {{DATA_WIDTH{1'b0}}, cin};
        one = {{DATA_WIDTH{1'b0}}, 1'b1};
        t   = '0;
        aa  = {a, a};
        amt = b[SH_W-1:0];
        rl  = aa << amt;
        rr  = aa >> amt;
        if (md) begin
            // Subtract-type results keep only the low byte; the borrow is reported on OFLOW.
            case (int'(cmd))
                0: begin o.res = ax + bx;      o.cout = o.res[DATA_WIDTH]; end
                1: begin t = ax - bx;          o.oflow = t[DATA_WIDTH]; o.res = {1'b0, t[DATA_WIDTH-1:0]}; end
                2: begin o.res = ax + bx + ci; o.cout = o.res[DATA_WIDTH]; end
                3: begin t = ax - bx - ci;     o.oflow = t[DATA_WIDTH]; o.res = {1'b0, t[DATA_WIDTH-1:0]}; end
                4: begin o.res = ax + one;     o.cout = o.res[DATA_WIDTH]; end
                5: begin t = ax - one;         o.oflow = t[DATA_WIDTH]; o.res = {1'b0, t[DATA_WIDTH-1:0]}; end
                6: begin o.res = bx + one;     o.cout = o.res[DATA_WIDTH]; end
                7: begin t = bx - one;         o.oflow = t[DATA_WIDTH]; o.res = {1'b0, t[DATA_WIDTH-1:0]}; end
                8: begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
                default: o.err = 1'b1;
            endcase
        end else begin
            case (int'(cmd))
                0:  o.res = {1'b0, a & b};
                1:  o.res = {1'b0, ~(a & b)};
                2:  o.res = {1'b0, a | b};
                3:  o.res = {1'b0, ~(a | b)};
                4:  o.res = {1'b0, a ^ b};
                5:  o.res = {1'b0, ~(a ^ b)};
                6:  o.res = {1'b0, ~a};
                7:  o.res = {1'b0, ~b};
                8:  o.res = {1'b0, a >> 1};
                9:  o.res = {1'b0, a << 1};
                10: o.res = {1'b0, b >> 1};
                11: o.res = {1'b0, b << 1};
                12: begin o.err = |b[DATA_WIDTH-1:4]; o.res = {1'b0, rl[2*DATA_WIDTH-1:DATA_WIDTH]}; end
                13: begin o.err = |b[DATA_WIDTH-1:4]; o.res = {1'b0, rr[DATA_WIDTH-1:0]}; end
                default: o.err = 1'b1;
            endcase
        end
        if (o.err) o.res = '0;
        return o;
    endfunction

    always_comb begin
        out_d    = out_q;
        drv_d    = drv_q;
        wait_d   = wait_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        mode_d   = mode_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        hold_a_d = hold_a_q;
        if (CE) begin
            if (wait_q) begin
                // A completing operand on the last wait cycle still wins over the timeout.
                if (hold_a_q ? INP_VALID[1] : INP_VALID[0]) begin
                    out_d  = exec(mode_q, cmd_q, hold_a_q ? opa_q : OPA, hold_a_q ? OPB : opb_q, CIN);
                    drv_d  = 1'b1;
                    wait_d = 1'b0;
                    cnt_d  = '0;
                end else if (cnt_q == 4'd15) begin
                    out_d  = err_out();
                    drv_d  = 1'b1;
                    wait_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else if (INP_VALID != 2'b00) begin
                drv_d = 1'b1;
                if (bad_cmd(MODE, CMD)) begin
                    out_d = err_out();
                end else if (need_a_only(MODE, CMD)) begin
                    out_d = INP_VALID[0] ? exec(MODE, CMD, OPA, OPB, CIN) : err_out();
                end else if (need_b_only(MODE, CMD)) begin
                    out_d = INP_VALID[1] ? exec(MODE, CMD, OPA, OPB, CIN) : err_out();
                end else if (INP_VALID == 2'b11) begin
                    out_d = exec(MODE, CMD, OPA, OPB, CIN);
                end else begin
                    drv_d    = drv_q;
                    wait_d   = 1'b1;
                    cnt_d    = '0;
                    cmd_d    = CMD;
                    mode_d   = MODE;
                    opa_d    = OPA;
                    opb_d    = OPB;
                    hold_a_d = INP_VALID[0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            out_q    <= '0;
            drv_q    <= 1'b0;
            wait_q   <= 1'b0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            mode_q   <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            hold_a_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            drv_q    <= drv_d;
            wait_q   <= wait_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            mode_q   <= mode_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            hold_a_q <= hold_a_d;
        end
    end

    assign RES   = drv_q ? out_q.res   : 'z;
    assign COUT  = drv_q ? out_q.cout  : 1'bz;
    assign OFLOW = drv_q ? out_q.oflow : 1'bz;
    assign G     = drv_q ? out_q.g     : 1'bz;
    assign L     = drv_q ? out_q.l     : 1'bz;
    assign E     = drv_q ? out_q.e     : 1'bz;
    assign ERR   = drv_q ? out_q.err   : 1'bz;

endmodule

// File: tb/tb_alu_modport.sv
// Bench for alu_modport: stimulus pushes per-cycle expected outputs from an integer model; a monitor pops and compares.
module tb_alu_modport;
    logic       clk = 1'b0;
    logic       RST, CE, CIN, MODE;
    logic [7:0] OPA, OPB;
    logic [1:0] INP_VALID;
    logic [3:0] CMD;
    wire  [8:0] RES;
    wire        COUT, OFLOW, G, L, E, ERR;

    always #5 clk = ~clk;

    alu_modport #(.DATA_WIDTH(8), .CMD_WIDTH(4)) dut (
        .clk(clk), .RST(RST), .CE(CE), .OPA(OPA), .OPB(OPB), .CIN(CIN), .MODE(MODE),
        .INP_VALID(INP_VALID), .CMD(CMD), .RES(RES), .COUT(COUT), .OFLOW(OFLOW),
        .G(G), .L(L), .E(E), .ERR(ERR)
    );

    typedef struct {
        bit    drv;
        int    res;
        bit    cout, oflow, g, l, e, err;
        string nm;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    bit m_wait, m_mode, m_hold_a;
    int m_cnt, m_cmd, m_a, m_b;

    function automatic exp_t blank();
        exp_t o;
        o.drv = 1; o.res = 0; o.cout = 0; o.oflow = 0;
        o.g = 0; o.l = 0; o.e = 0; o.err = 0; o.nm = "";
        return o;
    endfunction

    function automatic exp_t err_o();
        exp_t o;
        o = blank();
        o.err = 1;
        return o;
    endfunction

    function automatic exp_t ref_op(bit md, int cmd, int a, int b, bit cin);
        exp_t o;
        int   s;
        o = blank();
        s = b % 8;
        if (md) begin
            case (cmd)
                0: begin o.res = a + b;       o.cout = (o.res > 255); end
                1: begin o.oflow = (a < b);   o.res = (a - b) & 255; end
                2: begin o.res = a + b + cin; o.cout = (o.res > 255); end
                3: begin o.oflow = (a < b + cin); o.res = (a - b - cin) & 255; end
                4: begin o.res = a + 1; o.cout = (a == 255); end
                5: begin o.res = (a - 1) & 255; o.oflow = (a == 0); end
                6: begin o.res = b + 1; o.cout = (b == 255); end
                7: begin o.res = (b - 1) & 255; o.oflow = (b == 0); end
                8: begin o.g = (a > b); o.l = (a < b); o.e = (a == b); end
                default: o.err = 1;
            endcase
        end else begin
            case (cmd)
                0:  o.res = a & b;
                1:  o.res = ~(a & b) & 255;
                2:  o.res = a | b;
                3:  o.res = ~(a | b) & 255;
                4:  o.res = a ^ b;
                5:  o.res = ~(a ^ b) & 255;
                6:  o.res = ~a & 255;
                7:  o.res = ~b & 255;
                8:  o.res = a / 2;
                9:  o.res = (a * 2) % 256;
                10: o.res = b / 2;
                11: o.res = (b * 2) % 256;
                12: if (b >= 16) o.err = 1; else o.res = ((a << s) | (a >> (8 - s))) & 255;
                13: if (b >= 16) o.err = 1; else o.res = ((a >> s) | (a << (8 - s))) & 255;
                default: o.err = 1;
            endcase
        end
        if (o.err) o.res = 0;
        return o;
    endfunction

    function automatic bit only_a(bit md, int cmd);
        return md ? (cmd inside {4, 5}) : (cmd inside {6, 8, 9});
    endfunction

    function automatic bit only_b(bit md, int cmd);
        return md ? (cmd inside {6, 7}) : (cmd inside {7, 10, 11});
    endfunction

    function automatic bit invalid_cmd(bit md, int cmd);
        return md ? (cmd > 8) : (cmd > 13);
    endfunction

    task automatic step(input bit rst, input bit ce, input bit md, input int cmd, input int a,
                        input int b, input bit ci, input int iv, input string nm);
        exp_t e;
        @(negedge clk);
        RST = rst; CE = ce; MODE = md; CMD = cmd[3:0];
        OPA = a[7:0]; OPB = b[7:0]; CIN = ci; INP_VALID = iv[1:0];
        if (!rst) begin
            m_wait  = 0;
            m_cnt   = 0;
            cur.drv = 0;
        end else if (ce) begin
            if (m_wait) begin
                if (m_hold_a ? iv[1] : iv[0]) begin
                    cur    = ref_op(m_mode, m_cmd, m_hold_a ? m_a : a, m_hold_a ? b : m_b, ci);
                    m_wait = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == 16) begin
                        cur    = err_o();
                        m_wait = 0;
                    end
                end
            end else if (iv != 0) begin
                if (invalid_cmd(md, cmd))  cur = err_o();
                else if (only_a(md, cmd))  cur = iv[0] ? ref_op(md, cmd, a, b, ci) : err_o();
                else if (only_b(md, cmd))  cur = iv[1] ? ref_op(md, cmd, a, b, ci) : err_o();
                else if (iv == 3)          cur = ref_op(md, cmd, a, b, ci);
                else begin
                    m_wait = 1; m_cnt = 0; m_cmd = cmd; m_mode = md;
                    m_a = a; m_b = b; m_hold_a = iv[0];
                end
            end
        end
        e    = cur;
        e.nm = nm;
        q.push_back(e);
    endtask

    function automatic bit zl(logic v);
        return (v === 1'bz) || (v === 1'b0);
    endfunction

    initial begin
        forever begin
            exp_t e;
            bit   ok;
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.drv)
                    ok = (RES === 9'(e.res)) && (COUT === e.cout) && (OFLOW === e.oflow) &&
                         (G === e.g) && (L === e.l) && (E === e.e) && (ERR === e.err);
                else
                    ok = ((RES === 9'bz) || (RES === 9'd0)) && zl(COUT) && zl(OFLOW) &&
                         zl(G) && zl(L) && zl(E) && zl(ERR);
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL %s: got RES=%h COUT=%b OFLOW=%b G=%b L=%b E=%b ERR=%b, want driven=%0b RES=%h COUT=%b OFLOW=%b G=%b L=%b E=%b ERR=%b",
                             e.nm, RES, COUT, OFLOW, G, L, E, ERR,
                             e.drv, 9'(e.res), e.cout, e.oflow, e.g, e.l, e.e, e.err);
                end
            end
        end
    end

    initial begin
        RST = 0; CE = 0; MODE = 0; CMD = 0; OPA = 0; OPB = 0; CIN = 0; INP_VALID = 0;
        cur = blank();
        cur.drv = 0;
        m_wait = 0; m_cnt = 0; m_mode = 0; m_hold_a = 0; m_cmd = 0; m_a = 0; m_b = 0;

        step(0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        step(0, 1, 1, 0, 5, 3, 0, 3, "reset1");
        step(1, 1, 1, 0, 8'h05, 8'h03, 0, 3, "add_5_3");
        step(1, 1, 1, 0, 8'hff, 8'h01, 0, 3, "add_ff_1");
        step(0, 1, 1, 0, 8'h05, 8'h03, 0, 3, "rst_pulse");
        step(1, 1, 1, 0, 0, 0, 0, 0, "idle_after_rst");
        step(1, 1, 1, 0, 8'h05, 8'h03, 0, 3, "add_after_rst");
        step(1, 1, 1, 5, 8'h00, 8'h77, 0, 1, "dec_a_zero");
        step(1, 1, 1, 8, 8'h10, 8'h20, 0, 3, "cmp_lt");
        step(1, 1, 0, 12, 8'h81, 8'h01, 0, 3, "rol_by_1");
        step(1, 1, 0, 12, 8'h81, 8'h10, 0, 3, "rol_range_err");
        step(1, 1, 0, 13, 8'h81, 8'h0b, 0, 3, "ror_by_3");

        step(1, 1, 1, 0, 8'h40, 8'h00, 0, 1, "half_a_start");
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 8'h11, 8'h11, 0, 0, "half_a_wait");
        step(1, 1, 1, 0, 8'h99, 8'h22, 0, 3, "half_a_complete");

        step(1, 1, 1, 2, 8'h10, 8'h00, 1, 1, "timeout_start");
        for (int i = 1; i <= 16; i++) step(1, 1, 1, 0, 8'h33, 8'h44, 0, i % 2, "timeout_wait");
        step(1, 1, 1, 0, 0, 0, 0, 0, "timeout_hold");

        step(1, 1, 1, 1, 8'h00, 8'h30, 0, 2, "sub_half_b");
        for (int i = 0; i < 15; i++) step(1, 1, 1, 0, 8'h01, 8'h01, 0, 0, "sub_wait");
        step(1, 1, 1, 0, 8'h50, 8'h00, 0, 1, "sub_on_16th");

        step(1, 0, 1, 0, 8'h12, 8'h34, 0, 3, "ce_low0");
        step(1, 0, 0, 4, 8'hff, 8'h01, 1, 3, "ce_low1");
        step(1, 0, 1, 9, 8'h00, 8'h00, 0, 1, "ce_low2");
        step(1, 1, 1, 12, 8'h01, 8'h02, 0, 3, "cmd12_err");
        step(1, 1, 1, 6, 8'h01, 8'h02, 0, 1, "inc_b_no_b_err");
        step(1, 1, 1, 3, 8'h05, 8'h05, 1, 3, "sub_cin_borrow");

        step(1, 1, 1, 0, 8'h01, 8'h02, 0, 1, "mid_wait_start");
        step(0, 1, 1, 0, 8'h01, 8'h02, 0, 3, "rst_mid_wait");
        step(1, 1, 1, 0, 8'h03, 8'h04, 0, 2, "new_half_b");
        step(1, 1, 1, 0, 8'h09, 8'h09, 0, 1, "new_half_complete");

        for (int i = 0; i < 800; i++) begin
            bit rst, ce, md, ci;
            int cmd, a, b, iv;
            rst = ($urandom_range(0, 99) != 0);
            ce  = ($urandom_range(0, 9) != 0);
            md  = 1'($urandom_range(0, 1));
            ci  = 1'($urandom_range(0, 1));
            cmd = int'($urandom_range(0, 15));
            a   = int'($urandom_range(0, 255));
            b   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
            iv  = int'($urandom_range(0, 3));
            step(rst, ce, md, cmd, a, b, ci, iv, "random");
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
